// File: rtl/cache_hierarchy_types.sv
// rtl/cache_hierarchy_types.sv - shared cache hierarchy types and victim fill FSM states
package cache_hierarchy_types;

    // One victim cache entry: line address plus a 256-bit data line
    typedef struct packed {
        logic [31:0]  address;
        logic [255:0] data;
    } vc_t;

    typedef enum logic [1:0] {
        VCF_IDLE   = 2'd0,
        VCF_WB     = 2'd1,
        VCF_INSERT = 2'd2
    } vc_fill_state_t;

endpackage

// File: rtl/vc_fill_ctrl_free_slot_finder.sv
// rtl/vc_fill_ctrl_free_slot_finder.sv - priority encoder returning the lowest invalid entry
module vc_free_slot_finder #(
    parameter int entries = 8
) (
    input  logic [entries-1:0]         valid,
    output logic                       found,
    output logic [$clog2(entries)-1:0] idx
);

    localparam int iw = $clog2(entries);

    // Scan from the top down so the lowest-index free slot is the last one written
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = entries - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                found = 1'b1;
                idx   = i[iw-1:0];
            end
        end
    end

endmodule

// File: rtl/vc_fill_ctrl.sv
// rtl/vc_fill_ctrl.sv - victim cache fill side: slot choice, dirty writeback, entry load
module vc_fill_ctrl
    import cache_hierarchy_types::*;
#(
    parameter int entries = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       evict_valid,
    input  vc_t                        evict_line,
    input  logic                       evict_dirty,
    output logic                       evict_ready,
    input  logic                       inval_valid,
    input  logic [$clog2(entries)-1:0] inval_idx,
    input  vc_t  [entries-1:0]         vc_ts,
    output logic [entries-1:0]         load,
    output logic [31:0]                address_in,
    output logic [255:0]               data_in,
    output logic [entries-1:0]         valid_out,
    output logic                       pmem_write,
    output logic [31:0]                pmem_address,
    output logic [255:0]               pmem_wdata,
    input  logic                       pmem_resp
);

    localparam int iw = $clog2(entries);
    localparam logic [entries-1:0] one_hot_base = {{(entries-1){1'b0}}, 1'b1};

    generate
        if (entries < 2 || (entries & (entries - 1)) != 0) begin : g_bad_entries
            $error("vc_fill_ctrl: entries must be a power of two and at least 2");
        end
    endgenerate

    vc_fill_state_t     state;
    logic [entries-1:0] valid_q;
    logic [entries-1:0] dirty_q;
    logic [iw-1:0]      fifo_ptr;
    logic [iw-1:0]      target;
    logic               new_dirty;

    logic               free_found;
    logic [iw-1:0]      free_idx;
    logic [iw-1:0]      pick;

    vc_free_slot_finder #(.entries(entries)) u_free (
        .valid (valid_q),
        .found (free_found),
        .idx   (free_idx)
    );

    // Empty slots always win over the FIFO pointer
    assign pick      = free_found ? free_idx : fifo_ptr;
    assign valid_out = valid_q;

    // Fill FSM; address_in/data_in and pmem_address/pmem_wdata double as the
    // latched new line and latched victim, so they stay stable through WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= VCF_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            fifo_ptr     <= '0;
            target       <= '0;
            new_dirty    <= 1'b0;
            load         <= '0;
            evict_ready  <= 1'b0;
            pmem_write   <= 1'b0;
            address_in   <= '0;
            data_in      <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            // Invalidation first so a same-edge insert to that index overrides it
            if (inval_valid) begin
                valid_q[inval_idx] <= 1'b0;
                dirty_q[inval_idx] <= 1'b0;
            end
            case (state)
                VCF_IDLE: begin
                    if (evict_valid && evict_ready) begin
                        address_in   <= evict_line.address;
                        data_in      <= evict_line.data;
                        new_dirty    <= evict_dirty;
                        target       <= pick;
                        pmem_address <= vc_ts[pick].address;
                        pmem_wdata   <= vc_ts[pick].data;
                        evict_ready  <= 1'b0;
                        if (valid_q[pick] && dirty_q[pick]) begin
                            state      <= VCF_WB;
                            pmem_write <= 1'b1;
                        end else begin
                            state <= VCF_INSERT;
                            load  <= one_hot_base << pick;
                        end
                    end else begin
                        evict_ready <= 1'b1;
                    end
                end
                VCF_WB: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        load       <= one_hot_base << target;
                        state      <= VCF_INSERT;
                    end
                end
                VCF_INSERT: begin
                    load            <= '0;
                    valid_q[target] <= 1'b1;
                    dirty_q[target] <= new_dirty;
                    if (target == fifo_ptr) begin
                        fifo_ptr <= fifo_ptr + 1'b1;
                    end
                    evict_ready <= 1'b1;
                    state       <= VCF_IDLE;
                end
                default: begin
                    load        <= '0;
                    pmem_write  <= 1'b0;
                    evict_ready <= 1'b0;
                    state       <= VCF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_fill_ctrl.sv
// tb/tb_vc_fill_ctrl.sv - self-checking bench for vc_fill_ctrl against a slot-level model
module tb_vc_fill_ctrl;
    import cache_hierarchy_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         evict_valid;
    vc_t          evict_line;
    logic         evict_dirty;
    logic         evict_ready;
    logic         inval_valid;
    logic [2:0]   inval_idx;
    vc_t  [7:0]   arr;
    logic [7:0]   load;
    logic [31:0]  address_in;
    logic [255:0] data_in;
    logic [7:0]   valid_out;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each slot should hold and the replacement pointer
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [31:0]  m_addr  [8];
    logic [255:0] m_data  [8];
    int           m_ptr;

    vc_fill_ctrl #(.entries(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evict_valid  (evict_valid),
        .evict_line   (evict_line),
        .evict_dirty  (evict_dirty),
        .evict_ready  (evict_ready),
        .inval_valid  (inval_valid),
        .inval_idx    (inval_idx),
        .vc_ts        (arr),
        .load         (load),
        .address_in   (address_in),
        .data_in      (data_in),
        .valid_out    (valid_out),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Entry arrays the controller writes into
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (load[i]) arr[i] <= {address_in, data_in};
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_ptr = 0;
    endtask

    // Called #1 after an edge with the DUT idle.
    // inv_mode: 0 none, 1 inval on the insert edge, 2 inval on the first WB edge;
    // inv_idx < 0 means "the slot being filled".
    task automatic do_evict(input logic [31:0] addr, input bit dirty, input int delay,
                            input int inv_mode, input int inv_idx);
        logic [255:0] data;
        int t, ii;
        bit wb;
        logic [7:0] oh;
        data = rand_data();
        t = m_ptr;
        for (int i = 7; i >= 0; i--) if (!m_valid[i]) t = i;
        wb = m_valid[t] && m_dirty[t];
        ii = (inv_idx < 0) ? t : inv_idx;
        oh = 8'b1 << t;
        chk("ready_idle", evict_ready, 1'b1);
        evict_valid = 1'b1;
        evict_line  = '{address: addr, data: data};
        evict_dirty = dirty;
        @(posedge clk); #1;
        evict_valid = 1'b0;
        if (wb) begin
            for (int k = 0; k < delay; k++) begin
                chk("wb_write", pmem_write, 1'b1);
                chk("wb_addr", pmem_address, m_addr[t]);
                chk("wb_data", pmem_wdata, m_data[t]);
                chk("wb_ready", evict_ready, 1'b0);
                chk("wb_noload", load, 8'h00);
                if (inv_mode == 2 && k == 0) begin
                    inval_valid = 1'b1;
                    inval_idx   = ii[2:0];
                end
                if (k == delay - 1) pmem_resp = 1'b1;
                @(posedge clk); #1;
                if (inv_mode == 2 && k == 0) begin
                    inval_valid = 1'b0;
                    m_valid[ii] = 1'b0;
                    m_dirty[ii] = 1'b0;
                end
            end
            pmem_resp = 1'b0;
        end
        chk("ins_load", load, oh);
        chk("ins_addr", address_in, addr);
        chk("ins_data", data_in, data);
        chk("ins_nowrite", pmem_write, 1'b0);
        chk("ins_ready", evict_ready, 1'b0);
        if (inv_mode == 1) begin
            inval_valid = 1'b1;
            inval_idx   = ii[2:0];
        end
        @(posedge clk); #1;
        if (inv_mode == 1) begin
            inval_valid = 1'b0;
            m_valid[ii] = 1'b0;
            m_dirty[ii] = 1'b0;
        end
        m_valid[t] = 1'b1;
        m_dirty[t] = dirty;
        m_addr[t]  = addr;
        m_data[t]  = data;
        if (t == m_ptr) m_ptr = (m_ptr + 1) % 8;
        chk("post_load", load, 8'h00);
        chk("post_valid", valid_out, model_valid());
    endtask

    task automatic do_inval(input int idx);
        inval_valid = 1'b1;
        inval_idx   = idx[2:0];
        @(posedge clk); #1;
        inval_valid = 1'b0;
        m_valid[idx] = 1'b0;
        m_dirty[idx] = 1'b0;
        chk("inval_valid", valid_out, model_valid());
    endtask

    initial begin
        arr         = '0;
        rst_n       = 1'b0;
        evict_valid = 1'b0;
        evict_line  = '0;
        evict_dirty = 1'b0;
        inval_valid = 1'b0;
        inval_idx   = '0;
        pmem_resp   = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", evict_ready, 1'b0);
        chk("rst_load", load, 8'h00);
        chk("rst_valid", valid_out, 8'h00);
        chk("rst_write", pmem_write, 1'b0);
        chk("rst_addr_in", address_in, 32'h0);
        chk("rst_pmem_addr", pmem_address, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", evict_ready, 1'b1);

        // Clean fill of all eight slots, then a ninth replaces slot 0
        for (int i = 1; i <= 8; i++) do_evict(32'(i) << 12, 1'b0, 1, 0, 0);
        do_evict(32'h9000, 1'b0, 1, 0, 0);
        chk("ninth_valid", valid_out, 8'hFF);

        // Full with dirty slot 0 holding 0x1000: writeback held 5 cycles
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_evict(32'h1000, 1'b1, 1, 0, 0);
        for (int i = 2; i <= 8; i++) do_evict(32'(i) << 12, 1'b0, 1, 0, 0);
        do_evict(32'hA000, 1'b0, 5, 0, 0);

        // Freed slot 3 is preferred; pointer (now 1) is untouched
        do_inval(3);
        do_evict(32'hB000, 1'b1, 1, 0, 0);
        do_evict(32'hC000, 1'b0, 1, 0, 0);

        // Inval of slot 2 on the same edge as its insert: insert wins
        do_inval(2);
        do_evict(32'hD000, 1'b0, 1, 1, -1);
        chk("collide_valid2", valid_out[2], 1'b1);

        // Inval of the victim slot during writeback: insert still lands
        do_evict(32'hE000, 1'b1, 3, 2, -1);
        chk("wb_inval_valid3", valid_out[3], 1'b1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_inval(int'($urandom_range(0, 7)));
            else
                do_evict($urandom & 32'hFFFF_FFE0, 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                         ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 7)));
        end

        // Async reset in the middle of a writeback
        for (int i = 0; i < 8; i++) do_evict(32'h2_0000 + (32'(i) << 5), 1'b1, 1, 0, 0);
        chk("pre_rst_full", valid_out, 8'hFF);
        evict_valid = 1'b1;
        evict_line  = '{address: 32'h3_0000, data: rand_data()};
        evict_dirty = 1'b1;
        @(posedge clk); #1;
        evict_valid = 1'b0;
        chk("midwb_write", pmem_write, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_write", pmem_write, 1'b0);
        chk("arst_valid", valid_out, 8'h00);
        chk("arst_ready", evict_ready, 1'b0);
        chk("arst_pmem_addr", pmem_address, 32'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_ready", evict_ready, 1'b1);
        chk("arst_rel_load", load, 8'h00);
        do_evict(32'h4_0000, 1'b0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
